// File: rtl/markov_pkg.sv
// Shared defaults, FSM state encoding and LFSR feedback taps for the Markov note engine.
package markov_pkg;

  localparam int unsigned NOTE_W_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned LFSR_MIN_W = 16;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_DRAW  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

  // Right-shifting Galois feedback masks (maximal length) for 16..24-bit registers.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      16:      lfsr_taps = 32'h0000_B400;
      17:      lfsr_taps = 32'h0001_2000;
      18:      lfsr_taps = 32'h0002_0400;
      19:      lfsr_taps = 32'h0007_2000;
      20:      lfsr_taps = 32'h0009_0000;
      21:      lfsr_taps = 32'h0014_0000;
      22:      lfsr_taps = 32'h0030_0000;
      23:      lfsr_taps = 32'h0042_0000;
      24:      lfsr_taps = 32'h00E1_0000;
      default: lfsr_taps = 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/markov_note_engine_if.sv
// Learn-input and generate-output handshakes of the Markov note engine.
interface markov_note_engine_if
  import markov_pkg::*;
#(
  parameter int unsigned NOTE_W = NOTE_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [NOTE_W-1:0] in_note;
  logic              out_valid;
  logic              out_ready;
  logic [NOTE_W-1:0] out_note;
  logic              out_dead_end;

  modport master (
    output in_valid, in_note, out_ready,
    input  in_ready, out_valid, out_note, out_dead_end
  );

  modport slave (
    input  in_valid, in_note, out_ready,
    output in_ready, out_valid, out_note, out_dead_end
  );
endinterface

// File: rtl/markov_lfsr.sv
// Galois LFSR used as the random source for weighted note draws.
module markov_lfsr
  import markov_pkg::*;
#(
  parameter int unsigned W = LFSR_MIN_W
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  input  logic [W-1:0] seed,
  output logic [W-1:0] value
);
  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic [W-1:0] r_value;

  // Reload the seed on reset, otherwise step once per advance request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= seed;
    end else if (advance) begin
      r_value <= (r_value >> 1) ^ (r_value[0] ? TAPS : '0);
    end
  end

  assign value = r_value;
endmodule

// File: rtl/markov_note_engine.sv
// First-order Markov note engine: learns note transitions, then emits weighted random successors.
module markov_note_engine
  import markov_pkg::*;
#(
  parameter int unsigned NOTE_W = NOTE_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter logic [15:0] SEED   = 16'hACE1
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 clear,
  markov_note_engine_if.slave  bus,
  output logic                 busy
);
  localparam int unsigned NUM_NOTES = 1 << NOTE_W;
  localparam int unsigned TOT_W     = CNT_W + NOTE_W;
  localparam int unsigned LFSR_W    = (TOT_W > LFSR_MIN_W) ? TOT_W : LFSR_MIN_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count [NUM_NOTES][NUM_NOTES];
  logic [TOT_W-1:0]  r_total [NUM_NOTES];
  logic [NOTE_W-1:0] r_prev;
  logic              r_has_prev;
  logic [NOTE_W-1:0] r_row;
  logic [NOTE_W-1:0] r_col;
  logic [TOT_W-1:0]  r_cum;
  logic [NOTE_W-1:0] r_out_note;
  logic              r_out_dead_end;
  logic              r_out_valid;
  logic              r_busy;

  logic [LFSR_W-1:0] w_lfsr;
  logic [TOT_W-1:0]  w_r;
  logic [TOT_W-1:0]  w_row_total;
  logic [TOT_W-1:0]  w_cum_next;
  logic [CNT_W-1:0]  w_learn_cnt;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_draw_reject;
  logic              w_lfsr_adv;

  assign w_r           = w_lfsr[TOT_W-1:0];
  assign w_row_total   = r_total[r_prev];
  assign w_cum_next    = r_cum + TOT_W'(r_count[r_prev][r_col]);
  assign w_learn_cnt   = r_count[r_prev][bus.in_note];
  assign w_in_ready    = rst_n & (r_state == ST_IDLE) & ~mode & ~clear;
  assign w_accept      = w_in_ready & bus.in_valid;
  assign w_draw_reject = (r_state == ST_DRAW) && (w_row_total != '0) && (w_r >= w_row_total);
  assign w_lfsr_adv    = w_draw_reject || ((r_state == ST_EMIT) && bus.out_ready);

  markov_lfsr #(.W(LFSR_W)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (w_lfsr_adv),
    .seed    (LFSR_W'(SEED)),
    .value   (w_lfsr)
  );

  // Only the low TOT_W bits feed the draw; the rest only serve the LFSR period.
  generate
    if (LFSR_W > TOT_W) begin : g_lfsr_hi
      logic w_lfsr_unused;
      assign w_lfsr_unused = ^w_lfsr[LFSR_W-1:TOT_W];
    end
  endgenerate

  // Transition table: row-by-row wipe while clearing, saturating increment on learn.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_CLEAR) begin
        for (int unsigned n = 0; n < NUM_NOTES; n++) begin
          r_count[r_row][NOTE_W'(n)] <= '0;
        end
        r_total[r_row] <= '0;
      end else if (w_accept && r_has_prev && (w_learn_cnt != CNT_MAX)) begin
        r_count[r_prev][bus.in_note] <= w_learn_cnt + CNT_W'(1);
        r_total[r_prev]              <= w_row_total + TOT_W'(1);
      end
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_CLEAR;
      r_row          <= '0;
      r_col          <= '0;
      r_cum          <= '0;
      r_prev         <= '0;
      r_has_prev     <= 1'b0;
      r_out_note     <= '0;
      r_out_dead_end <= 1'b0;
      r_out_valid    <= 1'b0;
      r_busy         <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_prev     <= '0;
          r_has_prev <= 1'b0;
          r_row      <= r_row + NOTE_W'(1);
          if (r_row == NOTE_W'(NUM_NOTES - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_row   <= '0;
            r_busy  <= 1'b1;
          end else if (mode) begin
            r_state <= ST_DRAW;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_prev     <= bus.in_note;
            r_has_prev <= 1'b1;
          end
        end
        ST_DRAW: begin
          // An empty row has no successor, so the current note repeats itself.
          if (w_row_total == '0) begin
            r_out_note     <= r_prev;
            r_out_dead_end <= 1'b1;
            r_out_valid    <= 1'b1;
            r_state        <= ST_EMIT;
          end else if (w_r < w_row_total) begin
            r_cum   <= '0;
            r_col   <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_cum_next > w_r) begin
            r_out_note     <= r_col;
            r_out_dead_end <= 1'b0;
            r_out_valid    <= 1'b1;
            r_state        <= ST_EMIT;
          end else begin
            r_cum <= w_cum_next;
            r_col <= r_col + NOTE_W'(1);
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            r_prev      <= r_out_note;
            r_out_valid <= 1'b0;
            r_state     <= mode ? ST_DRAW : ST_IDLE;
            r_busy      <= mode;
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_row       <= '0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_note     = r_out_note;
  assign bus.out_dead_end = r_out_dead_end;
  assign busy             = r_busy;
endmodule

// File: tb/tb_markov_note_engine.sv
// Directed + randomized bench for markov_note_engine against a transaction-level reference model.
module tb_markov_note_engine;
  localparam int unsigned NOTE_W   = 4;
  localparam int unsigned NUM      = 16;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          WAIT_MAX = 40000;

  logic clk = 1'b0;
  logic rst_n;
  bit   sel1;
  logic mode_d, clear_d, in_valid_d, out_ready_d;
  logic [NOTE_W-1:0] in_note_d;
  logic busy0, busy1;

  markov_note_engine_if #(.NOTE_W(NOTE_W)) if0 ();
  markov_note_engine_if #(.NOTE_W(NOTE_W)) if1 ();

  assign if0.in_valid  = ~sel1 & in_valid_d;
  assign if0.in_note   = in_note_d;
  assign if0.out_ready = ~sel1 & out_ready_d;
  assign if1.in_valid  = sel1 & in_valid_d;
  assign if1.in_note   = in_note_d;
  assign if1.out_ready = sel1 & out_ready_d;

  logic              obs_in_ready, obs_out_valid, obs_dead, obs_busy;
  logic [NOTE_W-1:0] obs_out_note;
  assign obs_in_ready  = sel1 ? if1.in_ready     : if0.in_ready;
  assign obs_out_valid = sel1 ? if1.out_valid    : if0.out_valid;
  assign obs_out_note  = sel1 ? if1.out_note     : if0.out_note;
  assign obs_dead      = sel1 ? if1.out_dead_end : if0.out_dead_end;
  assign obs_busy      = sel1 ? busy1            : busy0;

  markov_note_engine #(.NOTE_W(4), .CNT_W(8), .SEED(SEED)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (~sel1 & mode_d),
    .clear (~sel1 & clear_d),
    .bus   (if0),
    .busy  (busy0)
  );

  markov_note_engine #(.NOTE_W(4), .CNT_W(2), .SEED(SEED)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (sel1 & mode_d),
    .clear (sel1 & clear_d),
    .bus   (if1),
    .busy  (busy1)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: plain counts, row totals, last note and the random source.
  int m_cnt [NUM][NUM];
  int m_tot [NUM];
  int m_prev;
  bit m_has_prev;
  int m_lfsr;
  int m_cmax;
  int m_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_step(input int x);
    if (x[0]) return ((x >> 1) ^ 32'h0000_B400) & 32'h0000_FFFF;
    return (x >> 1) & 32'h0000_FFFF;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NUM; p++) begin
      m_tot[p] = 0;
      for (int n = 0; n < NUM; n++) m_cnt[p][n] = 0;
    end
    m_prev = 0;
    m_has_prev = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_lfsr = 32'(SEED);
  endtask

  task automatic model_learn(input int n);
    if (m_has_prev && m_cnt[m_prev][n] < m_cmax) begin
      m_cnt[m_prev][n]++;
      m_tot[m_prev]++;
    end
    m_prev = n;
    m_has_prev = 1'b1;
  endtask

  // Rejection-sample r below the row total, then pick the column whose running sum passes r.
  task automatic model_draw(output int note, output bit dead);
    int r, acc, guard;
    note = m_prev;
    dead = 1'b1;
    if (m_tot[m_prev] != 0) begin
      dead = 1'b0;
      guard = 0;
      while ((m_lfsr & m_mask) >= m_tot[m_prev] && guard < 1000000) begin
        m_lfsr = lfsr_step(m_lfsr);
        guard++;
      end
      r = m_lfsr & m_mask;
      acc = 0;
      for (int n = 0; n < NUM; n++) begin
        acc += m_cnt[m_prev][n];
        if (acc > r) begin
          note = n;
          break;
        end
      end
    end
  endtask

  task automatic learn(input int n);
    int k;
    k = 0;
    mode_d = 1'b0;
    in_note_d = NOTE_W'(n);
    in_valid_d = 1'b1;
    while (obs_in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("learn_ready", 32'(obs_in_ready), 32'd1);
    @(posedge clk);
    model_learn(n);
    @(negedge clk);
  endtask

  task automatic learn_pattern();
    for (int i = 0; i < 100; i++) begin
      learn(0); learn(1); learn(0); learn(2);
    end
    learn(0);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (obs_out_valid !== 1'b1 && k < WAIT_MAX) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(obs_out_valid), 32'd1);
  endtask

  task automatic draw1(input string tag, input bit mode_after, output int got);
    int en;
    bit ed;
    in_valid_d = 1'b0;
    mode_d = 1'b1;
    wait_valid(tag);
    model_draw(en, ed);
    got = int'(obs_out_note);
    check({tag, "_note"}, 32'(obs_out_note), 32'(en));
    check({tag, "_dead"}, 32'(obs_dead), 32'(ed));
    out_ready_d = 1'b1;
    mode_d = mode_after;
    @(posedge clk);
    m_prev = en;
    m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
    out_ready_d = 1'b0;
  endtask

  task automatic do_clear();
    int bc;
    bc = 0;
    in_valid_d = 1'b0;
    mode_d = 1'b0;
    clear_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_d = 1'b0;
    model_clear();
    while (obs_busy === 1'b1 && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    check("clear_busy_cycles", 32'(bc), 32'd16);
  endtask

  task automatic do_reset(input string tag);
    int bc;
    bc = 0;
    in_valid_d = 1'b0;
    mode_d = 1'b0;
    clear_d = 1'b0;
    out_ready_d = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rst_out_valid"}, 32'(obs_out_valid), 32'd0);
    check({tag, "_rst_out_note"}, 32'(obs_out_note), 32'd0);
    check({tag, "_rst_dead"}, 32'(obs_dead), 32'd0);
    check({tag, "_rst_in_ready"}, 32'(obs_in_ready), 32'd0);
    check({tag, "_rst_busy"}, 32'(obs_busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    while (obs_busy === 1'b1 && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(bc), 32'd16);
    check({tag, "_in_ready_after"}, 32'(obs_in_ready), 32'd1);
  endtask

  initial begin
    int got, en, n1, n2;
    bit ed;
    checks = 0;
    errors = 0;
    sel1 = 1'b0;
    rst_n = 1'b0;
    mode_d = 1'b0;
    clear_d = 1'b0;
    in_valid_d = 1'b0;
    in_note_d = '0;
    out_ready_d = 1'b0;
    m_cmax = 255;
    m_mask = 32'h0FFF;
    model_reset();
    @(negedge clk);

    do_reset("por");

    // Two equally weighted successors of note 0.
    learn_pattern();

    // Stalled output must hold steady and must not consume randomness.
    in_valid_d = 1'b0;
    mode_d = 1'b1;
    wait_valid("stall");
    model_draw(en, ed);
    check("stall_note", 32'(obs_out_note), 32'(en));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold_valid", 32'(obs_out_valid), 32'd1);
      check("stall_hold_note", 32'(obs_out_note), 32'(en));
      check("stall_hold_dead", 32'(obs_dead), 32'(ed));
    end
    out_ready_d = 1'b1;
    mode_d = 1'b0;
    @(posedge clk);
    m_prev = en;
    m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
    out_ready_d = 1'b0;
    learn(0);

    // Distribution of successors of note 0.
    n1 = 0;
    n2 = 0;
    for (int i = 0; i < 1000; i++) begin
      draw1("stats", 1'b0, got);
      if (got == 1) n1++;
      else if (got == 2) n2++;
      learn(0);
    end
    check("stats_only_1_or_2", 32'(n1 + n2), 32'd1000);
    check("stats_share1_40_60", 32'(n1 >= 400 && n1 <= 600), 32'd1);
    check("stats_share2_40_60", 32'(n2 >= 400 && n2 <= 600), 32'd1);

    // Reset while an output is pending.
    in_valid_d = 1'b0;
    mode_d = 1'b1;
    wait_valid("pre_rst");
    do_reset("emit_rst");

    // Same seed and same training must replay the same draw sequence.
    learn_pattern();
    for (int i = 0; i < 50; i++) begin
      draw1("replay", 1'b0, got);
      learn(0);
    end

    // Learn 3,5,3,5,3: the only successor of 3 is 5.
    do_clear();
    learn(3); learn(5); learn(3); learn(5); learn(3);
    draw1("p3", 1'b0, got);
    check("p3_is_5", 32'(got), 32'd5);

    // Empty table: the current note repeats as a dead end.
    do_clear();
    learn(7);
    for (int i = 0; i < 3; i++) begin
      draw1("dead", (i < 2), got);
      check("dead_is_7", 32'(got), 32'd7);
      check("dead_flag", 32'(obs_dead), 32'd1);
    end

    // Narrow counters must saturate rather than wrap.
    in_valid_d = 1'b0;
    sel1 = 1'b1;
    m_cmax = 3;
    m_mask = 32'h003F;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      learn(1); learn(2);
    end
    learn(1); learn(3); learn(1);
    for (int i = 0; i < 8; i++) begin
      draw1("sat", 1'b0, got);
      check("sat_succ_2_or_3", 32'(got == 2 || got == 3), 32'd1);
      learn(1);
    end
    in_valid_d = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/markov_note_engine.md
MARKOV_NOTE_ENGINE -- requirements
Module: markov_note_engine

Interface
REQ-001 Parameter NOTE_W, default 4: note code width; NUM_NOTES = 2**NOTE_W.
REQ-002 Parameter CNT_W, default 8: transition-count width; row-total width TOT_W = CNT_W+NOTE_W.
REQ-003 Parameter SEED, default 16'hACE1: LFSR reset value, SHALL be nonzero.
REQ-004 Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mode  in  1  0 = learn, 1 = generate; sampled only in IDLE.
- clear  in  1  pulse; wipes table; sampled only in IDLE.
- in_valid  in  1  learn note valid.
- in_ready  out  1  learn note accepted when in_valid & in_ready.
- in_note  in  NOTE_W  learn note code.
- out_valid  out  1  generated note valid.
- out_ready  in  1  downstream accepts.
- out_note  out  NOTE_W  generated note code.
- out_dead_end  out  1  qualifies out_valid; current row had zero total.
- busy  out  1  high in every state except IDLE.

Function
REQ-005 States: CLEAR, IDLE, DRAW, SCAN, EMIT; no other states.
REQ-006 Table: count[p][n], CNT_W bits each; total[p], TOT_W bits; prev register, NOTE_W bits; has_prev flag.
REQ-007 CLEAR: zero one row (counts and total) per cycle, rows 0..NUM_NOTES-1 ascending; clear has_prev and prev; go to IDLE after row NUM_NOTES-1 (NUM_NOTES cycles).
REQ-008 IDLE priority: clear, then mode=1 (go to DRAW), then learn.
REQ-009 Learn: in_ready = 1 in IDLE with mode=0 and clear=0; 0 in all other cases.
REQ-010 On learn accept with has_prev=1: if count[prev][in_note] < 2**CNT_W-1, increment it and total[prev]; otherwise leave both unchanged (saturate).
REQ-011 Every learn accept: prev <= in_note; has_prev <= 1; single cycle; back-to-back accepts SHALL be supported.
REQ-012 A learn accept with has_prev=0 updates no counts.
REQ-013 DRAW: r = LFSR low TOT_W bits (LFSR width = max(16, TOT_W)).
- If total[prev] = 0: out_note <= prev; out_dead_end <= 1; go to EMIT.
- Else if r < total[prev]: clear cumulative sum; set column index to 0; go to SCAN.
- Else: advance LFSR and stay in DRAW (rejection).
REQ-014 SCAN: one column per cycle; cum += count[prev][col].
- If cum > r: out_note <= col; out_dead_end <= 0; go to EMIT.
- Else: col increments.
- Terminates within NUM_NOTES cycles.
REQ-015 EMIT: out_valid = 1 and holds out_note and out_dead_end stable until out_ready.
REQ-016 On EMIT handshake: prev <= out_note; advance LFSR.
- mode=1: go to DRAW.
- mode=0: go to IDLE.
REQ-017 A dead-end note is re-emitted each draw until the table changes (self-loop).
REQ-018 out_valid = 0 outside EMIT.
REQ-019 LFSR advances only in DRAW rejection and on EMIT handshake, so sequences are reproducible from SEED.
REQ-020 mode and clear changes outside IDLE are ignored until IDLE is reached.

Reset
REQ-021 rst_n=0 at a clock edge, in any state including mid-SCAN or EMIT, SHALL enter CLEAR and reload LFSR with SEED.
REQ-022 Output values during and after reset: out_valid=0; out_note=0; out_dead_end=0; in_ready=0; busy=1.
REQ-023 The table is zeroed by the CLEAR sequence, not by a bulk reset of the array.

Structure
REQ-024 Package markov_pkg holds:
- default NOTE_W and CNT_W;
- the state enumeration;
- the LFSR feedback taps.
REQ-025 Sub-module markov_lfsr: Galois LFSR with ports clk, rst_n, advance, seed, value.
REQ-026 Target size 120-400 lines RTL.

Verification
REQ-027 Reset mid-EMIT -> out_valid=0 next cycle; busy=1 for 16 cycles (NOTE_W=4); then in_ready=1 in learn mode.
REQ-028 Learn 3,5,3,5,3 -> count[3][5]=2, count[5][3]=2, total[3]=2; generate from prev=3 -> out_note=5, out_dead_end=0.
REQ-029 CNT_W=2; learn 1,2 repeated six times -> count[1][2]=3 (saturated), total[1]=3, no wrap to 0.
REQ-030 Generate with an empty table, prev=7 -> out_note=7, out_dead_end=1; repeats every handshake.
REQ-031 out_ready held low 10 cycles in EMIT -> out_note stable, out_valid=1 throughout; LFSR unchanged.
REQ-032 Learn 0->1 and 0->2 100 times each; draw 1000 notes from prev=0 -> only 1 or 2 emitted, each 40-60 %; identical sequence after re-reset with the same SEED.
